ob_deskew_writer: RTL and testbench
===================================

// Module: ob_deskew_writer
// PURPOSE
//  Downstream of the systolic-array core. Takes column-skewed results (col c arrives c cycles after col 0),
//  deskews them into whole rows and writes each row to the output buffer SRAM (active-low cenb/wenb).
//  Writes start at a base address. Signals done after a programmed number of rows.
// PARAMETERS
//  WIDTH   8    bits per result element
//  COL     4    array columns = elements per output row
//  O_SIZE  512  output buffer depth; ADDR_W = $clog2(O_SIZE)
// PORTS
//  clk_i          in   1             clock
//  rst_i          in   1             synchronous reset, active high
//  start_i        in   1             rising edge launches a job; must return to 0 before the next job
//  num_rows_i     in   ADDR_W+1      rows to write; captured on start edge
//  base_addr_i    in   ADDR_W        first write address; captured on start edge
//  sa_valid_i     in   COL           per-column result valid (skewed)
//  sa_data_i      in   COL*WIDTH     [COL-1:0][WIDTH-1:0] per-column results (skewed)
//  ob_mem_cenb_o  out  1             SRAM enable, active low
//  ob_mem_wenb_o  out  1             SRAM write enable, active low
//  ob_mem_addr_o  out  ADDR_W        SRAM address
//  ob_mem_data_o  out  COL*WIDTH     SRAM write data, col c at bits [c*WIDTH +: WIDTH]
//  busy_o         out  1             job in progress
//  done_o         out  1             high in IDLE, including after reset
//  skew_err_o     out  1             sticky: aligned valids disagreed
// BEHAVIOUR
//  Reset: FSM=IDLE, all delay lines flushed (valid=0), cenb=wenb=1, addr=0, data=0, busy=0,
//   done=1, skew_err=0, start_q=0, row counter=0.
//  Start detection: start_q <= start_i; launch = start_i & ~start_q & (state==IDLE).
//  FSM: IDLE --launch & num_rows!=0--> RUN. RUN --last row written--> IDLE.
//   launch with num_rows==0: stay IDLE, done stays 1, no writes.
//  Deskew: col c delayed COL-1-c cycles (col COL-1 undelayed); valid delayed with its data.
//  Row is aligned when all COL delayed valids are 1 in the same cycle.
//  In RUN with an aligned row: on the next edge cenb=0, wenb=0, addr=base+cnt, data=aligned row, cnt++.
//  Latency: col-0 sample at cycle t -> write strobe visible at cycle t+COL (one cycle wide per row).
//  Last write: the strobe for row num_rows-1 and the return to IDLE occur on the same edge (done=1, busy=0).
//  Address arithmetic: modulo 2^ADDR_W, so base+cnt wraps past O_SIZE-1 to 0.
//  Partial alignment (some, not all, delayed valids =1): no write, skew_err<=1 (sticky to reset).
//   Counted in any state.
//  Aligned row in IDLE: dropped, no write, no error.
//  start edge in RUN: ignored, captured config unchanged.
//  rst_i mid-job: immediate return to reset state; in-flight rows discarded; no further strobes.
//  Outputs registered; cenb/wenb return to 1 in every cycle without a write.
// CONFIGURATION
//  `OB_WB_PERF_CNT_EN defined: adds port dropped_cnt_o (out,16): counts aligned rows dropped in IDLE.
//   Saturates at 16'hFFFF; cleared by rst_i only.
//  Not defined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package mm_pkg: ob_wb_state_e {IDLE,RUN} typedef, ADDR_W helper, row_t packed-array typedef.
//  Sub-module ob_delay_line #(WIDTH,DEPTH):
//   - shift register of {valid,data}, sync active-high reset clears valid.
//   - DEPTH=0 is a passthrough.
//   - one instance per column via generate.
// TESTING
//  1 COL=4. Reset, base=10, num_rows=3, 3 correctly skewed rows (col c of row r = 16*r+c):
//    3 strobes, addr 10,11,12, data {8'h03,02,01,00}/{13..10}/{23..20}; done rises with the 3rd strobe.
//  2 Latency: one row with col0 valid at cycle t -> cenb=wenb=0 exactly at t+4; no strobe at t+3 or t+5.
//  3 Wrap: base=510, num_rows=4 -> addresses 510,511,0,1.
//  4 Col2 valid dropped for one row -> skew_err=1; that row is not written.
//    Next good row goes to the same address; skew_err stays 1 until rst_i.
//  5 Reset after 2 of 5 rows: outputs return to reset values next edge.
//    Remaining skewed inputs produce no strobes. New start, num_rows=1 -> writes to base.
//  6 num_rows=0 start -> no strobe, done stays 1. Rows in IDLE -> no write
//    (PERF_CNT_EN: dropped_cnt_o increments per row).

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and helpers for the output-buffer deskew writer.
// Optional build macro used by the top: OB_WB_PERF_CNT_EN.
package mm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ob_wb_state_e;

  localparam int OB_WIDTH  = 8;
  localparam int OB_COL    = 4;
  localparam int OB_O_SIZE = 512;

  // One deskewed output row, element c at bits [c*OB_WIDTH +: OB_WIDTH].
  typedef logic [OB_COL-1:0][OB_WIDTH-1:0] row_t;

  function automatic int ob_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ob_delay_line.sv
// Fixed-depth {valid,data} shift register; reset clears the valid bits.
// DEPTH=0 degenerates to a wire.
module ob_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign valid_o = valid_i;
      assign data_o  = data_i;
    end else begin : g_shift
      logic [DEPTH-1:0]            valid_q;
      logic [DEPTH-1:0][WIDTH-1:0] data_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q[0] <= valid_i;
          data_q[0]  <= data_i;
          for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
          end
        end
      end

      assign valid_o = valid_q[DEPTH-1];
      assign data_o  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ob_deskew_writer.sv
// Deskews column-staggered array results into rows and writes them to the output SRAM.
// Define OB_WB_PERF_CNT_EN to add dropped_cnt_o (aligned rows discarded while idle).
module ob_deskew_writer
  import mm_pkg::*;
#(
  parameter  int WIDTH  = OB_WIDTH,
  parameter  int COL    = OB_COL,
  parameter  int O_SIZE = OB_O_SIZE,
  localparam int ADDR_W = ob_addr_w(O_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_W:0]      num_rows_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [COL-1:0]       sa_valid_i,
  input  logic [COL*WIDTH-1:0] sa_data_i,
  output logic                 ob_mem_cenb_o,
  output logic                 ob_mem_wenb_o,
  output logic [ADDR_W-1:0]    ob_mem_addr_o,
  output logic [COL*WIDTH-1:0] ob_mem_data_o,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef OB_WB_PERF_CNT_EN
  output logic [15:0]          dropped_cnt_o,
`endif
  output logic                 skew_err_o
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [COL-1:0]       dvalid;
  logic [COL*WIDTH-1:0] drow;

  // Column c arrives c cycles late, so it needs COL-1-c cycles of delay to line up.
  for (genvar gi = 0; gi < COL; gi++) begin : g_col
    ob_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (COL-1-gi)
    ) u_delay (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (sa_valid_i[gi]),
      .data_i  (sa_data_i[gi*WIDTH +: WIDTH]),
      .valid_o (dvalid[gi]),
      .data_o  (drow[gi*WIDTH +: WIDTH])
    );
  end

  logic aligned;
  logic partial;
  logic launch;

  assign aligned = &dvalid;
  assign partial = (|dvalid) & ~aligned;

  ob_wb_state_e         state_q, state_d;
  logic                 start_q;
  logic [ADDR_W:0]      cnt_q, cnt_d;
  logic [ADDR_W:0]      num_rows_q, num_rows_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COL*WIDTH-1:0] data_q, data_d;
  logic                 cenb_q, cenb_d;
  logic                 wenb_q, wenb_d;
  logic                 skew_err_q, skew_err_d;
  logic [ADDR_W:0]      cnt_inc;

  assign launch  = start_i & ~start_q & (state_q == IDLE);
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_rows_d = num_rows_q;
    base_d     = base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cenb_d     = 1'b1;
    wenb_d     = 1'b1;
    skew_err_d = skew_err_q | partial;

    case (state_q)
      IDLE: begin
        if (launch && (num_rows_i != '0)) begin
          state_d    = RUN;
          num_rows_d = num_rows_i;
          base_d     = base_addr_i;
          cnt_d      = '0;
        end
      end
      RUN: begin
        if (aligned) begin
          cenb_d = 1'b0;
          wenb_d = 1'b0;
          // Truncation to ADDR_W gives the wrap past the top of the buffer.
          addr_d = base_q + cnt_q[ADDR_W-1:0];
          data_d = drow;
          cnt_d  = cnt_inc;
          if (cnt_inc == num_rows_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      num_rows_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cenb_q     <= 1'b1;
      wenb_q     <= 1'b1;
      skew_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_i;
      cnt_q      <= cnt_d;
      num_rows_q <= num_rows_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cenb_q     <= cenb_d;
      wenb_q     <= wenb_d;
      skew_err_q <= skew_err_d;
    end
  end

`ifdef OB_WB_PERF_CNT_EN
  logic [15:0] dropped_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dropped_q <= '0;
    end else if ((state_q == IDLE) && aligned && (dropped_q != 16'hFFFF)) begin
      dropped_q <= dropped_q + 16'd1;
    end
  end

  assign dropped_cnt_o = dropped_q;
`endif

  assign ob_mem_cenb_o = cenb_q;
  assign ob_mem_wenb_o = wenb_q;
  assign ob_mem_addr_o = addr_q;
  assign ob_mem_data_o = data_q;
  assign busy_o        = (state_q == RUN);
  assign done_o        = (state_q == IDLE);
  assign skew_err_o    = skew_err_q;

endmodule

// File: tb/tb_ob_deskew_writer.sv
// Randomised bench for ob_deskew_writer against a row-history reference model.
// Honours OB_WB_PERF_CNT_EN for the optional dropped-row counter.
module tb_ob_deskew_writer;
  import mm_pkg::*;

  localparam int NCYC = 8192;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [9:0]  num_rows_i = '0;
  logic [8:0]  base_addr_i = '0;
  logic [3:0]  sa_valid_i = '0;
  logic [31:0] sa_data_i = '0;
  logic        ob_mem_cenb_o, ob_mem_wenb_o, busy_o, done_o, skew_err_o;
  logic [8:0]  ob_mem_addr_o;
  logic [31:0] ob_mem_data_o;
`ifdef OB_WB_PERF_CNT_EN
  logic [15:0] dropped_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  ob_deskew_writer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .num_rows_i    (num_rows_i),
    .base_addr_i   (base_addr_i),
    .sa_valid_i    (sa_valid_i),
    .sa_data_i     (sa_data_i),
    .ob_mem_cenb_o (ob_mem_cenb_o),
    .ob_mem_wenb_o (ob_mem_wenb_o),
    .ob_mem_addr_o (ob_mem_addr_o),
    .ob_mem_data_o (ob_mem_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
`ifdef OB_WB_PERF_CNT_EN
    .dropped_cnt_o (dropped_cnt_o),
`endif
    .skew_err_o    (skew_err_o)
  );

  // Row history indexed by the cycle in which column 0 of that row is presented.
  logic [3:0] hv [0:NCYC-1];
  row_t       hd [0:NCYC-1];
  int         cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, in terms of jobs and rows.
  logic        m_run = 1'b0;
  int          m_cnt = 0;
  int          m_nrows = 0;
  int          m_base = 0;
  logic        m_err = 1'b0;
  logic        m_sprev = 1'b0;
  int          m_drop = 0;
  int          n_strobe = 0;
  int          strobe_cyc = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive skewed inputs from history, advance the model, compare after the edge.
  task automatic tick(input logic st, input logic rs, input logic [3:0] mask, input row_t data);
    int          k;
    int          j;
    logic [3:0]  v;
    logic [31:0] rowd;
    logic        e_wr;
    logic [8:0]  e_addr;
    logic [31:0] e_data;
    k = cyc;
    hv[k] = mask;
    hd[k] = data;
    start_i = st;
    rst_i   = rs;
    for (int c = 0; c < 4; c++) begin
      j = k - c;
      sa_valid_i[c]         = (j >= 0) ? hv[j][c] : 1'b0;
      sa_data_i[c*8 +: 8]   = (j >= 0) ? hd[j][c] : 8'h00;
    end
    j    = k - 3;
    v    = (j >= 0) ? hv[j] : 4'h0;
    rowd = (j >= 0) ? hd[j] : 32'h0;
    e_wr   = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (rs) begin
      m_run = 1'b0; m_cnt = 0; m_err = 1'b0; m_sprev = 1'b0; m_drop = 0;
      // Column samples already taken for rows still in flight are lost.
      for (int jj = k - 2; jj <= k; jj++)
        if (jj >= 0)
          for (int c = 0; c < 3; c++)
            if (jj + c <= k) hv[jj][c] = 1'b0;
    end else begin
      if (v != 4'h0 && v != 4'hF) m_err = 1'b1;
      if (m_run) begin
        if (v == 4'hF) begin
          e_wr   = 1'b1;
          e_addr = 9'((m_base + m_cnt) % 512);
          e_data = rowd;
          m_cnt++;
          if (m_cnt == m_nrows) m_run = 1'b0;
        end
      end else begin
        if (v == 4'hF && m_drop < 65535) m_drop++;
        if (st && !m_sprev && num_rows_i != 0) begin
          m_run = 1'b1; m_base = int'(base_addr_i); m_nrows = int'(num_rows_i); m_cnt = 0;
        end
      end
      m_sprev = st;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    chk("cenb", ob_mem_cenb_o, !e_wr);
    chk("wenb", ob_mem_wenb_o, !e_wr);
    chk("busy", busy_o, m_run);
    chk("done", done_o, !m_run);
    chk("skew_err", skew_err_o, m_err);
    if (e_wr || rs) begin
      chk("addr", ob_mem_addr_o, e_addr);
      chk("data", ob_mem_data_o, e_data);
    end
`ifdef OB_WB_PERF_CNT_EN
    chk("dropped", dropped_cnt_o, 64'(m_drop));
`endif
    if (!ob_mem_cenb_o) begin
      n_strobe++;
      strobe_cyc = cyc;
    end
  endtask

  function automatic row_t pat_row(input int r);
    row_t x;
    for (int c = 0; c < 4; c++) x[c] = 8'(16 * r + c);
    return x;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, '0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1, 4'h0, '0);
    tick(1'b0, 1'b1, 4'h0, '0);
  endtask

  task automatic go(input int base, input int nrows);
    base_addr_i = 9'(base);
    num_rows_i  = 10'(nrows);
    tick(1'b1, 1'b0, 4'h0, '0);
  endtask

  initial begin
    int t0;
    int s0;
    int r;
    logic [3:0] m;
    for (int i = 0; i < NCYC; i++) begin
      hv[i] = '0;
      hd[i] = '0;
    end

    // Reset, then three correctly skewed rows to base 10.
    do_reset();
    go(10, 3);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'hF, pat_row(i));
    idle(6);

    // Single-row latency: strobe exactly COL cycles after column 0.
    go(0, 1);
    s0 = n_strobe;
    t0 = cyc;
    tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    idle(6);
    chk("latency", 64'(strobe_cyc - t0), 64'd4);
    chk("latency_count", 64'(n_strobe - s0), 64'd1);

    // Address wrap past the top of the buffer.
    go(510, 4);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    idle(6);

    // Column 2 missing for one row.
    go(40, 2);
    tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    tick(1'b0, 1'b0, 4'b1011, row_t'($urandom));
    tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    idle(8);
    chk("skew_sticky", skew_err_o, 1'b1);

    // Reset after two of five rows, then a fresh one-row job.
    go(100, 5);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    s0 = n_strobe;
    tick(1'b0, 1'b1, 4'h0, '0);
    idle(6);
    chk("no_strobe_after_rst", 64'(n_strobe - s0), 64'd0);
    go(100, 1);
    tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    idle(6);

    // Zero-row job, and rows presented while idle.
    do_reset();
    s0 = n_strobe;
    go(7, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'hF, row_t'($urandom));
    idle(6);
    chk("idle_no_write", 64'(n_strobe - s0), 64'd0);
    chk("idle_done", done_o, 1'b1);

    // Random jobs with gaps, bad rows and stray start pulses.
    for (int job = 0; job < 12; job++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      go(int'($urandom_range(0, 511)), int'($urandom_range(1, 6)));
      for (int i = 0; i < 80 && m_run; i++) begin
        r = int'($urandom_range(0, 9));
        m = (r == 0) ? 4'($urandom) : (r == 1) ? 4'h0 : 4'hF;
        tick(($urandom_range(0, 9) == 0), 1'b0, m, row_t'($urandom));
      end
      idle(5);
      chk("job_done", done_o, !m_run);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
